// File: rtl/fpu_add_arbiter_pkg.sv
// Shared types and size constants for the two-requester FP add/sub arbiter.
package fpu_add_arbiter_pkg;

  typedef enum logic [1:0] {StIdle, StLoad, StWait, StResp} state_e;
  typedef enum logic [1:0] {CoreIdle, CoreAdd, CoreNorm, CoreRound} core_state_e;

  localparam int unsigned ExpW32  = 8;
  localparam int unsigned ManW32  = 23;
  localparam int unsigned ExpW64  = 11;
  localparam int unsigned ManW64  = 52;
  localparam int unsigned CyclesW = 8;

  function automatic int unsigned exp_width(input int unsigned precision);
    return (precision == 64) ? ExpW64 : ExpW32;
  endfunction

  function automatic int unsigned man_width(input int unsigned precision);
    return (precision == 64) ? ManW64 : ManW32;
  endfunction

endpackage

// File: rtl/float_adder_subtractor.sv
// Multi-cycle IEEE-754 adder/subtractor: special operands finish one cycle after load,
// ordinary operands take align/add, normalise and round cycles. Not reset.
module float_adder_subtractor
  import fpu_add_arbiter_pkg::*;
#(
  parameter int unsigned Precision = 32
) (
  input  logic                 clk_i,
  input  logic                 load_i,
  input  logic [Precision-1:0] a_i,
  input  logic [Precision-1:0] b_i,
  input  logic                 op_i,
  output logic [Precision-1:0] result_o,
  output logic                 valid_o
);

  localparam int unsigned EW = exp_width(Precision);
  localparam int unsigned MW = man_width(Precision);
  localparam int unsigned XW = MW + 4;  // hidden bit, fraction, guard/round/sticky
  localparam int unsigned PW = EW + 1;
  localparam logic [EW-1:0] ExpMax = '1;

  core_state_e          cst_q;
  logic [Precision-1:0] a_q, b_q, res_q;
  logic                 op_q, sign_q, valid_q;
  logic [XW:0]          sum_q;
  logic [XW-1:0]        norm_q;
  logic [PW-1:0]        exp_q;

  function automatic int unsigned lzc(input logic [XW-1:0] v);
    int unsigned n = XW;
    for (int i = 0; i < XW; i++) begin
      if (v[i]) n = XW - 1 - i;
    end
    return n;
  endfunction

  logic                 sa, sb, sx, sy, swap, a_nan, b_nan, a_inf, b_inf, spec_hit, sticky;
  logic [EW-1:0]        ea, eb, ea_n, eb_n, ex, ey, dsh;
  logic [MW:0]          ma, mb, mx, my;
  logic [2*XW-1:0]      wide;
  logic [XW-1:0]        y_eff;
  logic [XW:0]          sum_d;
  logic [Precision-1:0] spec_res;

  always_comb begin
    sa    = a_q[Precision-1];
    sb    = b_q[Precision-1] ^ op_q;
    ea    = a_q[Precision-2 -: EW];
    eb    = b_q[Precision-2 -: EW];
    a_nan = (ea == ExpMax) && (a_q[MW-1:0] != '0);
    b_nan = (eb == ExpMax) && (b_q[MW-1:0] != '0);
    a_inf = (ea == ExpMax) && (a_q[MW-1:0] == '0);
    b_inf = (eb == ExpMax) && (b_q[MW-1:0] == '0);
    ea_n  = (ea == '0) ? EW'(1) : ea;
    eb_n  = (eb == '0) ? EW'(1) : eb;
    ma    = {ea != '0, a_q[MW-1:0]};
    mb    = {eb != '0, b_q[MW-1:0]};
    swap  = (eb_n > ea_n) || ((eb_n == ea_n) && (mb > ma));
    ex    = swap ? eb_n : ea_n;
    ey    = swap ? ea_n : eb_n;
    mx    = swap ? mb : ma;
    my    = swap ? ma : mb;
    sx    = swap ? sb : sa;
    sy    = swap ? sa : sb;
    dsh   = ((ex - ey) > EW'(XW)) ? EW'(XW) : (ex - ey);
    // Bits shifted out of the smaller operand collapse into the sticky LSB.
    wide   = {my, 3'b000, {XW{1'b0}}} >> dsh;
    sticky = |wide[XW-1:0];
    y_eff  = {wide[2*XW-1:XW+1], wide[XW] | sticky};
    if (sx == sy) sum_d = {1'b0, mx, 3'b000} + {1'b0, y_eff};
    else          sum_d = {1'b0, mx, 3'b000} - {1'b0, y_eff};
    spec_hit = a_nan | b_nan | a_inf | b_inf;
    if (a_nan || b_nan || (a_inf && b_inf && (sa != sb))) begin
      spec_res = {1'b0, {(Precision-1){1'b1}}};
    end else if (a_inf) begin
      spec_res = {sa, a_q[Precision-2:0]};
    end else begin
      spec_res = {sb, b_q[Precision-2:0]};
    end
  end

  int unsigned   sh;
  logic [PW-1:0] exp_n;
  logic [XW-1:0] norm_d;

  always_comb begin
    sh = 0;
    if (sum_q[XW]) begin
      norm_d = {sum_q[XW:2], sum_q[1] | sum_q[0]};
      exp_n  = exp_q + PW'(1);
    end else begin
      // Never shift below the minimum exponent; the result then stays subnormal.
      sh = lzc(sum_q[XW-1:0]);
      if (sh > 32'(exp_q) - 1) sh = 32'(exp_q) - 1;
      norm_d = sum_q[XW-1:0] << sh;
      exp_n  = exp_q - PW'(sh);
    end
  end

  logic                 rnd_up, hidden;
  logic [MW+1:0]        m;
  logic [MW-1:0]        frac;
  logic [PW-1:0]        exp_r;
  logic [Precision-1:0] packed_res;

  always_comb begin
    rnd_up = norm_q[2] & (norm_q[1] | norm_q[0] | norm_q[3]);
    m      = {1'b0, norm_q[XW-1:3]} + {{(MW+1){1'b0}}, rnd_up};
    if (m[MW+1]) begin
      frac   = m[MW:1];
      hidden = 1'b1;
      exp_r  = exp_q + PW'(1);
    end else begin
      frac   = m[MW-1:0];
      hidden = m[MW];
      exp_r  = exp_q;
    end
    if (exp_r >= {1'b0, ExpMax}) packed_res = {sign_q, ExpMax, {MW{1'b0}}};
    else packed_res = {sign_q, hidden ? exp_r[EW-1:0] : {EW{1'b0}}, frac};
  end

  always_ff @(posedge clk_i) begin
    if (load_i) begin
      a_q     <= a_i;
      b_q     <= b_i;
      op_q    <= op_i;
      valid_q <= 1'b0;
      cst_q   <= CoreAdd;
    end else begin
      case (cst_q)
        CoreAdd: begin
          if (spec_hit) begin
            res_q   <= spec_res;
            valid_q <= 1'b1;
            cst_q   <= CoreIdle;
          end else begin
            sum_q  <= sum_d;
            exp_q  <= {1'b0, ex};
            sign_q <= (sum_d == '0) ? (sx & sy) : sx;
            cst_q  <= CoreNorm;
          end
        end
        CoreNorm: begin
          norm_q <= norm_d;
          exp_q  <= exp_n;
          cst_q  <= CoreRound;
        end
        CoreRound: begin
          res_q   <= packed_res;
          valid_q <= 1'b1;
          cst_q   <= CoreIdle;
        end
        default: ;
      endcase
    end
  end

  assign result_o = res_q;
  assign valid_o  = valid_q;

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant: a lone request wins; a tie goes to the one not granted last.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  assign grant[0] = req[0] & (~req[1] | last_grant);
  assign grant[1] = req[1] & (~req[0] | ~last_grant);

endmodule

// File: rtl/fpu_add_arbiter.sv
// Shares one FP add/sub core between two requesters, one operation at a time,
// with round-robin arbitration and a registered response holding stage.
module fpu_add_arbiter
  import fpu_add_arbiter_pkg::*;
#(
  parameter int unsigned PRECISION = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [PRECISION-1:0] req0_a,
  input  logic [PRECISION-1:0] req0_b,
  input  logic                 req0_op,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [PRECISION-1:0] req1_a,
  input  logic [PRECISION-1:0] req1_b,
  input  logic                 req1_op,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [PRECISION-1:0] rsp_result,
  output logic [CyclesW-1:0]   rsp_cycles,
  output logic                 busy
);

  state_e               state_q;
  logic                 last_grant_q, op_q, id_q, rsp_valid_q;
  logic [PRECISION-1:0] a_q, b_q, result_q;
  logic [CyclesW-1:0]   cycles_q;
  logic [1:0]           grant;
  logic                 idle, hs0, hs1, core_valid;
  logic [PRECISION-1:0] core_result;

  rr_arbiter2 u_arb (
    .req        ({req1_valid, req0_valid}),
    .last_grant (last_grant_q),
    .grant      (grant)
  );

  float_adder_subtractor #(
    .Precision (PRECISION)
  ) u_core (
    .clk_i    (clk),
    .load_i   (state_q == StLoad),
    .a_i      (a_q),
    .b_i      (b_q),
    .op_i     (op_q),
    .result_o (core_result),
    .valid_o  (core_valid)
  );

  assign idle       = (state_q == StIdle);
  // Gated by rst_n so nothing looks accepted while reset is held.
  assign req0_ready = rst_n & idle & grant[0];
  assign req1_ready = rst_n & idle & grant[1];
  assign hs0        = req0_valid & req0_ready;
  assign hs1        = req1_valid & req1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      last_grant_q <= 1'b1;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= 1'b0;
      id_q         <= 1'b0;
      result_q     <= '0;
      cycles_q     <= '0;
      rsp_valid_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (hs0 || hs1) begin
            a_q          <= hs1 ? req1_a : req0_a;
            b_q          <= hs1 ? req1_b : req0_b;
            op_q         <= hs1 ? req1_op : req0_op;
            id_q         <= hs1;
            last_grant_q <= hs1;
            cycles_q     <= '0;
            state_q      <= StLoad;
          end
        end
        StLoad: state_q <= StWait;
        StWait: begin
          if (cycles_q != '1) cycles_q <= cycles_q + CyclesW'(1);
          if (core_valid) begin
            result_q    <= core_result;
            rsp_valid_q <= 1'b1;
            state_q     <= StResp;
          end
        end
        StResp: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = id_q;
  assign rsp_result = result_q;
  assign rsp_cycles = cycles_q;
  assign busy       = ~idle;

endmodule

// File: tb/tb_fpu_add_arbiter.sv
// Directed bench for fpu_add_arbiter with an expected-response scoreboard queue.
module tb_fpu_add_arbiter;

  localparam logic [31:0] F1   = 32'h3F800000;
  localparam logic [31:0] F2   = 32'h40000000;
  localparam logic [31:0] F3   = 32'h40400000;
  localparam logic [31:0] F5   = 32'h40A00000;
  localparam logic [31:0] PInf = 32'h7F800000;
  localparam logic [31:0] NInf = 32'hFF800000;
  localparam logic [31:0] QNan = 32'h7FFFFFFF;

  logic        clk, rst_n;
  logic        req0_valid, req0_ready, req0_op;
  logic        req1_valid, req1_ready, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp_valid, rsp_ready, rsp_id, busy;
  logic [31:0] rsp_result;
  logic [7:0]  rsp_cycles;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int hs_cyc   = 0;
  int lat, waits;
  logic exp_g, seen;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
  } sb_t;
  sb_t sb_q[$];
  sb_t ent;

  fpu_add_arbiter #(
    .PRECISION (32)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_op    (req0_op),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_op    (req1_op),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cycles (rsp_cycles),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
    check({tag, "_busy"}, 64'(busy), 64'd0);
    check({tag, "_ready"}, 64'({req1_ready, req0_ready}), 64'd0);
    check({tag, "_rsp_result"}, 64'(rsp_result), 64'd0);
    check({tag, "_rsp_id"}, 64'(rsp_id), 64'd0);
    check({tag, "_rsp_cycles"}, 64'(rsp_cycles), 64'd0);
  endtask

  // Called at a negedge; returns at the negedge after the handshake edge.
  task automatic send(input logic n, input logic [31:0] a, input logic [31:0] b,
                      input logic op, input logic [31:0] exp_res, input logic push);
    logic found = 1'b0;
    if (n) begin req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1; end
    else   begin req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1; end
    #1;
    for (int i = 0; i < 50 && !found; i++) begin
      if (n ? req1_ready : req0_ready) found = 1'b1;
      else begin @(negedge clk); #1; end
    end
    check("send_ready", 64'(found), 64'd1);
    if (found) begin
      if (push) begin ent.id = n; ent.res = exp_res; sb_q.push_back(ent); end
      hs_cyc = cyc;
      @(posedge clk);
      #1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);
  endtask

  // Returns at the negedge where rsp_valid is seen; lat counts from the handshake cycle.
  task automatic wait_rsp(input string tag, output int lat_o);
    logic got = 1'b0;
    sb_t  e;
    for (int i = 0; i < 100 && !got; i++) begin
      if (rsp_valid) got = 1'b1;
      else @(negedge clk);
    end
    check({tag, "_rsp_seen"}, 64'(got), 64'd1);
    lat_o = cyc - hs_cyc;
    if (got) begin
      if (sb_q.size() == 0) begin
        check({tag, "_sb_nonempty"}, 64'(sb_q.size()), 64'd1);
      end else begin
        e = sb_q.pop_front();
        check({tag, "_rsp_id"}, 64'(rsp_id), 64'(e.id));
        check({tag, "_rsp_result"}, 64'(rsp_result), 64'(e.res));
      end
    end
  endtask

  initial begin
    rst_n = 1'b0; rsp_ready = 1'b0;
    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = 1'b0;
    repeat (2) @(negedge clk);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    check_reset_outputs("reset");
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Both requesters held valid: grants alternate starting with requester 0.
    req0_a = F1; req0_b = F2; req0_op = 1'b0;
    req1_a = F3; req1_b = F1; req1_op = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    exp_g = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      waits = 0;
      while (!(req0_ready || req1_ready) && waits < 50) begin
        @(negedge clk);
        waits++;
      end
      check("tie_grant", 64'({req1_ready, req0_ready}), exp_g ? 64'd2 : 64'd1);
      if (k > 0) check("tie_back_to_back", 64'(waits), 64'd0);
      ent.id = exp_g; ent.res = exp_g ? F2 : F3;
      sb_q.push_back(ent);
      hs_cyc = cyc;
      @(posedge clk);
      #1;
      if (k == 3) begin req0_valid = 1'b0; req1_valid = 1'b0; end
      wait_rsp("tie", lat);
      @(negedge clk);
      exp_g = ~exp_g;
    end

    // Single requesters, rsp_ready already high before RESP.
    send(1'b0, F1, F2, 1'b0, F3, 1'b1);
    wait_rsp("add0", lat);
    @(negedge clk);
    check("add0_rsp_dropped", 64'(rsp_valid), 64'd0);
    check("add0_idle", 64'(busy), 64'd0);
    send(1'b1, F3, F1, 1'b1, F2, 1'b1);
    wait_rsp("sub1", lat);
    @(negedge clk);

    // inf + -inf: special case, minimum latency.
    send(1'b0, PInf, NInf, 1'b0, QNan, 1'b1);
    wait_rsp("inf", lat);
    check("inf_latency", 64'(lat), 64'd4);
    check("inf_rsp_cycles", 64'(rsp_cycles), 64'd2);
    @(negedge clk);

    // Back-pressure in RESP: everything holds, nobody is ready.
    rsp_ready = 1'b0;
    send(1'b0, 32'h0, F5, 1'b0, F5, 1'b1);
    wait_rsp("hold", lat);
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      check("hold_result", 64'(rsp_result), 64'(F5));
      check("hold_ready", 64'({req1_ready, req0_ready}), 64'd0);
      check("hold_busy_valid", 64'({busy, rsp_valid}), 64'd3);
      @(negedge clk);
      #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(negedge clk);
    check("hold_release_idle", 64'({busy, rsp_valid}), 64'd0);

    // Reset mid-WAIT abandons the operation.
    send(1'b0, F1, F2, 1'b0, F3, 1'b0);
    @(negedge clk);
    check("midwait_busy", 64'(busy), 64'd1);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midwait_reset");
    @(negedge clk);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      seen = seen | rsp_valid;
    end
    check("midwait_no_rsp", 64'(seen), 64'd0);
    send(1'b0, F1, F2, 1'b0, F3, 1'b1);
    wait_rsp("after_reset", lat);
    @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
